// File: rtl/eeprom_seq_ctrl.sv
// Byte-level sequencer between the I2C byte front end and the 32x8 EEPROM array.
// It decodes device/address/data bytes, buffers a page, commits it on STOP, then holds busy.
module eeprom_seq_ctrl #(
   parameter logic [6:0] DEV_ADDR   = 7'b1010000,
   parameter int         TWR_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic       byte_valid_i,
   input  logic [7:0] byte_i,
   input  logic       rd_req_i,
   output logic       ack_o,
   output logic [7:0] rd_data_o,
   output logic       rd_valid_o,
   output logic [4:0] mem_row_o,
   output logic [2:0] mem_col_o,
   output logic [7:0] mem_wdata_o,
   output logic       mem_we_o,
   output logic       mem_re_o,
   input  logic [7:0] mem_rdata_i,
   output logic       busy_o
);

   localparam int TW = $clog2(TWR_CYCLES + 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(TWR_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_DEV, S_WADDR, S_WDATA, S_COMMIT, S_WAIT, S_RDATA
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      addr_q, addr_d;
   logic [7:0]      vld_q, vld_d;
   logic [2:0]      idx_q, idx_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            ack_q, ack_d;
   logic [7:0]      rd_data_q, rd_data_d;
   logic            rd_valid_q, rd_valid_d;
   logic            buf_we;
   logic [7:0]      wbuf_q [8];

   logic ev_stop, ev_start, ev_byte, ev_rd;

   // Only the highest-priority event of a cycle is acted on.
   assign ev_stop  = stop_i;
   assign ev_start = !stop_i && start_i;
   assign ev_byte  = !stop_i && !start_i && byte_valid_i;
   assign ev_rd    = !stop_i && !start_i && !byte_valid_i && rd_req_i;

   assign ack_o      = ack_q;
   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
   assign busy_o     = (state_q == S_COMMIT) || (state_q == S_WAIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         vld_q      <= '0;
         idx_q      <= '0;
         tmr_q      <= '0;
         ack_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         vld_q      <= vld_d;
         idx_q      <= idx_d;
         tmr_q      <= tmr_d;
         ack_q      <= ack_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Page buffer holds data only; its valid bits live in the control registers above.
   always_ff @(posedge clk) begin
      if (buf_we) wbuf_q[addr_q[2:0]] <= byte_i;
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      vld_d       = vld_q;
      idx_d       = idx_q;
      tmr_d       = tmr_q;
      ack_d       = ack_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      buf_we      = 1'b0;
      mem_row_o   = '0;
      mem_col_o   = '0;
      mem_wdata_o = '0;
      mem_we_o    = 1'b0;
      mem_re_o    = 1'b0;

      if (ev_start) ack_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ev_start) state_d = S_DEV;
            else if (ev_byte) ack_d = 1'b0;
         end
         S_DEV: begin
            if (ev_stop) state_d = S_IDLE;
            else if (ev_start) state_d = S_DEV;
            else if (ev_byte) begin
               if (byte_i[7:1] == DEV_ADDR) begin
                  ack_d   = 1'b1;
                  state_d = byte_i[0] ? S_RDATA : S_WADDR;
               end else begin
                  ack_d   = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end
         S_WADDR: begin
            if (ev_stop) state_d = S_IDLE;
            else if (ev_start) state_d = S_DEV;
            else if (ev_byte) begin
               addr_d  = byte_i;
               vld_d   = '0;
               ack_d   = 1'b1;
               state_d = S_WDATA;
            end
         end
         S_WDATA: begin
            if (ev_stop) begin
               idx_d   = '0;
               state_d = (|vld_q) ? S_COMMIT : S_IDLE;
            end else if (ev_start) begin
               vld_d   = '0;
               state_d = S_DEV;
            end else if (ev_byte) begin
               buf_we              = 1'b1;
               vld_d[addr_q[2:0]]  = 1'b1;
               ack_d               = 1'b1;
               addr_d[2:0]         = addr_q[2:0] + 3'd1;
            end
         end
         S_COMMIT: begin
            mem_row_o   = addr_q[7:3];
            mem_col_o   = idx_q;
            mem_wdata_o = wbuf_q[idx_q];
            mem_we_o    = vld_q[idx_q];
            idx_d       = idx_q + 3'd1;
            if (ev_byte) ack_d = 1'b0;
            if (idx_q == 3'd7) begin
               tmr_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ev_byte) ack_d = 1'b0;
            if (tmr_q == TMR_LAST) state_d = S_IDLE;
            else tmr_d = tmr_q + 1'b1;
         end
         S_RDATA: begin
            if (ev_stop) state_d = S_IDLE;
            else if (ev_start) state_d = S_DEV;
            else if (ev_rd) begin
               mem_re_o   = 1'b1;
               mem_row_o  = addr_q[7:3];
               mem_col_o  = addr_q[2:0];
               rd_data_d  = mem_rdata_i;
               rd_valid_d = 1'b1;
               addr_d     = addr_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_eeprom_seq_ctrl.sv
// Randomized bench for eeprom_seq_ctrl against a transaction-level EEPROM model.
module tb_eeprom_seq_ctrl;

   localparam int TWR = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_i = 1'b0, stop_i = 1'b0, byte_valid_i = 1'b0, rd_req_i = 1'b0;
   logic [7:0] byte_i = '0;
   logic       ack_o, rd_valid_o, mem_we_o, mem_re_o, busy_o;
   logic [7:0] rd_data_o, mem_wdata_o, mem_rdata;
   logic [4:0] mem_row_o;
   logic [2:0] mem_col_o;

   logic [7:0] arr [256];
   logic [7:0] ref_mem [256];
   logic [7:0] ref_addr;
   logic       bd_we = 1'b0;
   logic [7:0] bd_a = '0, bd_d = '0;
   int         we_cnt = 0, both_cnt = 0;
   int         n_chk = 0, n_fail = 0;

   eeprom_seq_ctrl #(.DEV_ADDR(7'b1010000), .TWR_CYCLES(TWR)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
      .byte_valid_i(byte_valid_i), .byte_i(byte_i), .rd_req_i(rd_req_i),
      .ack_o(ack_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
      .mem_row_o(mem_row_o), .mem_col_o(mem_col_o), .mem_wdata_o(mem_wdata_o),
      .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_rdata_i(mem_rdata),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   assign mem_rdata = arr[{mem_row_o, mem_col_o}];

   always @(posedge clk) begin
      if (mem_we_o) begin
         arr[{mem_row_o, mem_col_o}] <= mem_wdata_o;
         we_cnt <= we_cnt + 1;
      end else if (bd_we) begin
         arr[bd_a] <= bd_d;
      end
      if (mem_we_o && mem_re_o) both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic backdoor(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk); bd_we = 1'b1; bd_a = a; bd_d = d;
      @(negedge clk); bd_we = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic do_start();
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      chk("ack_after_start", ack_o, 0);
   endtask

   task automatic do_stop();
      @(negedge clk); stop_i = 1'b1;
      @(negedge clk); stop_i = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic exp_ack, input string tag);
      @(negedge clk); byte_i = b; byte_valid_i = 1'b1;
      @(negedge clk); byte_valid_i = 1'b0;
      chk(tag, ack_o, exp_ack);
   endtask

   task automatic rd_byte();
      @(negedge clk); rd_req_i = 1'b1; #1;
      chk("mem_re", mem_re_o, 1);
      chk("re_addr", {mem_row_o, mem_col_o}, ref_addr);
      chk("re_no_we", mem_we_o, 0);
      @(negedge clk); rd_req_i = 1'b0;
      chk("rd_valid", rd_valid_o, 1);
      chk("rd_data", rd_data_o, ref_mem[ref_addr]);
      ref_addr = ref_addr + 8'd1;
   endtask

   task automatic busy_len(input int exp);
      int cyc = 0;
      while (busy_o && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
      chk("busy_len", cyc, exp);
   endtask

   task automatic wr_txn(input logic [7:0] dev, input logic [7:0] a, input int n);
      logic ok;
      logic [7:0] d;
      logic [7:0] loc;
      int base, distinct;
      ok = (dev == 8'hA0);
      base = we_cnt;
      do_start();
      send(dev, ok, "ack_dev");
      send(a, ok, "ack_waddr");
      for (int i = 0; i < n; i++) begin
         d = 8'($urandom);
         send(d, ok, "ack_wdata");
         if (ok) begin
            loc = {a[7:3], 3'((a[2:0] + i) % 8)};
            ref_mem[loc] = d;
         end
      end
      if (ok) ref_addr = {a[7:3], 3'((a[2:0] + n) % 8)};
      do_stop();
      busy_len((ok && n > 0) ? 8 + TWR : 0);
      distinct = ok ? ((n > 8) ? 8 : n) : 0;
      chk("we_count", we_cnt - base, distinct);
      for (int c = 0; c < 8; c++) begin
         loc = {a[7:3], 3'(c)};
         chk("page_data", arr[loc], ref_mem[loc]);
      end
   endtask

   task automatic rand_rd(input logic [7:0] a, input int n);
      do_start();
      send(8'hA0, 1, "ack_dev_w");
      send(a, 1, "ack_raddr");
      ref_addr = a;
      do_start();
      send(8'hA1, 1, "ack_dev_r");
      for (int i = 0; i < n; i++) rd_byte();
      do_stop();
      chk("rd_valid_pulse", rd_valid_o, 0);
   endtask

   task automatic cur_rd(input int n);
      do_start();
      send(8'hA1, 1, "ack_dev_r");
      for (int i = 0; i < n; i++) rd_byte();
      do_stop();
   endtask

   initial begin
      int base;
      int cyc;
      ref_addr = '0;
      for (int i = 0; i < 256; i++) backdoor(8'(i), 8'($urandom));
      @(negedge clk);
      chk("rst_ack", ack_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_rdv", rd_valid_o, 0);
      chk("rst_we", mem_we_o, 0);
      chk("rst_re", mem_re_o, 0);
      chk("rst_memaddr", {mem_row_o, mem_col_o, mem_wdata_o, rd_data_o}, 0);
      reset = 1'b0;
      @(negedge clk);

      // Page write, then page wrap
      wr_txn(8'hA0, 8'h13, 2);
      chk("addr_after_wr", ref_addr, 8'h15);
      cur_rd(1);
      wr_txn(8'hA0, 8'h1E, 3);
      cur_rd(1);

      // Random read with preloaded array, then 0xFF rollover
      backdoor(8'h13, 8'h5A);
      backdoor(8'h14, 8'hC3);
      rand_rd(8'h13, 2);
      rand_rd(8'hFF, 2);

      // Wrong device
      wr_txn(8'hA2, 8'h00, 1);

      // Restart inside a write discards the buffer but keeps the address
      base = we_cnt;
      do_start();
      send(8'hA0, 1, "ack_dev_w");
      send(8'h20, 1, "ack_waddr");
      send(8'h77, 1, "ack_wdata");
      ref_addr = 8'h21;
      do_start();
      send(8'hA1, 1, "ack_dev_r");
      rd_byte();
      do_stop();
      chk("discard_busy", busy_o, 0);
      chk("discard_we", we_cnt - base, 0);

      // ACK polling during the write cycle
      base = we_cnt;
      do_start();
      send(8'hA0, 1, "ack_dev_w");
      send(8'h50, 1, "ack_waddr");
      send(8'h99, 1, "ack_wdata");
      ref_mem[8'h50] = 8'h99;
      ref_addr = 8'h51;
      do_stop();
      do_start();
      send(8'hA0, 0, "poll_busy_nack");
      chk("poll_busy", busy_o, 1);
      cyc = 0;
      while (busy_o && cyc < 200) begin cyc++; @(negedge clk); end
      chk("poll_busy_end", busy_o, 0);
      do_start();
      send(8'hA0, 1, "poll_idle_ack");
      do_stop();
      chk("poll_we", we_cnt - base, 1);
      chk("poll_data", arr[8'h50], 8'h99);

      // Reset in the middle of a commit
      base = we_cnt;
      do_start();
      send(8'hA0, 1, "ack_dev_w");
      send(8'h40, 1, "ack_waddr");
      for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i), 1, "ack_wdata");
      do_stop();
      cyc = 0;
      while (we_cnt < base + 2 && cyc < 50) begin cyc++; @(negedge clk); end
      reset = 1'b1;
      #1;
      chk("rst_we_now", mem_we_o, 0);
      @(negedge clk);
      reset = 1'b0;
      ref_mem[8'h40] = 8'hE0;
      ref_mem[8'h41] = 8'hE1;
      repeat (12) @(negedge clk);
      chk("rst_we_total", we_cnt - base, 2);
      chk("rst_busy2", busy_o, 0);
      chk("rst_ack2", ack_o, 0);
      for (int c = 0; c < 4; c++) chk("rst_page", arr[8'h40 + 8'(c)], ref_mem[8'h40 + 8'(c)]);
      ref_addr = 8'h00;
      cur_rd(1);

      // Randomized mix of transactions
      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 3))
            0: wr_txn(8'hA0, 8'($urandom), int'($urandom_range(1, 10)));
            1: rand_rd(8'($urandom), int'($urandom_range(1, 5)));
            2: cur_rd(int'($urandom_range(1, 4)));
            default: wr_txn({7'h50 ^ 7'($urandom_range(1, 127)), 1'($urandom)},
                            8'($urandom), int'($urandom_range(0, 3)));
         endcase
      end

      chk("we_re_exclusive", both_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
